// File: rtl/leak_update_sequencer_if.sv
// ----------------------------------------------------------------------------
// leak_update_sequencer_if
//
// Purpose: groups every non-clock signal of leak_update_sequencer into one
// bundle, covering the sweep control, the shared leak-unit link, the
// injected-current write port, the spike output and the V readback port.
//
// Modports:
//   slave  - the sequencer itself (drives busy/done/tick_drop/leak_v/spike/
//            spike_idx/rd_v, receives tick/leak_i/iw_*/rd_idx)
//   master - the environment around it (timestep generator, leak unit,
//            current-write and readback clients)
//
// Signals (16s = 16-bit two's complement):
//   tick       1      start-sweep pulse
//   busy       1      sweep in progress
//   done       1      one-cycle pulse, sweep complete
//   tick_drop  1      one-cycle pulse, tick arrived while not idle
//   leak_v     16s    V handed to the leak unit
//   leak_i     16s    leak current returned by the leak unit
//   iw_en      1      injected-current write strobe
//   iw_idx     IDX_W  neuron index for the write
//   iw_val     16s    injected current value
//   spike      1      one-cycle spike pulse
//   spike_idx  IDX_W  neuron that spiked, valid with spike
//   rd_idx     IDX_W  readback index
//   rd_v       16s    V[rd_idx]
// ----------------------------------------------------------------------------
interface leak_update_sequencer_if #(
    parameter int IDX_W = 2
);
    logic                    tick;
    logic                    busy;
    logic                    done;
    logic                    tick_drop;
    logic signed [15:0]      leak_v;
    logic signed [15:0]      leak_i;
    logic                    iw_en;
    logic        [IDX_W-1:0] iw_idx;
    logic signed [15:0]      iw_val;
    logic                    spike;
    logic        [IDX_W-1:0] spike_idx;
    logic        [IDX_W-1:0] rd_idx;
    logic signed [15:0]      rd_v;

    modport slave (
        input  tick, leak_i, iw_en, iw_idx, iw_val, rd_idx,
        output busy, done, tick_drop, leak_v, spike, spike_idx, rd_v
    );

    modport master (
        output tick, leak_i, iw_en, iw_idx, iw_val, rd_idx,
        input  busy, done, tick_drop, leak_v, spike, spike_idx, rd_v
    );
endinterface

// File: rtl/leak_update_sequencer.sv
// ----------------------------------------------------------------------------
// leak_update_sequencer
//
// Purpose: time-multiplexes one shared leak-current unit across NUM_NEURONS
// membrane potentials. A tick starts a sweep; for each neuron the sequencer
// hands V to the leak unit, waits LEAK_LAT cycles for I_L, integrates
//   V += I_in - (I_L >>> DECAY_SHIFT)   (18-bit, saturated to 16 bits)
// and fires a spike (V <- V_RESET) when the result reaches V_TH.
// The V and I_in register files live here.
//
// Ports:
//   clk  in  clock, all logic on the rising edge
//   rst  in  synchronous reset, active high; aborts a running sweep
//   bus  leak_update_sequencer_if.slave (see interface header for signals)
//
// Optional feature, macro LEAK_SEQ_REFRAC_EN:
//   defined   - per-neuron refractory counter loaded with REFRAC_TICKS on a
//               spike; while non-zero the neuron is held at V_RESET and does
//               not integrate or spike, and the counter decrements per sweep.
//   undefined - no refractory period; a spiked neuron integrates next sweep.
// ----------------------------------------------------------------------------
module leak_update_sequencer #(
    parameter int NUM_NEURONS  = 4,
    parameter int IDX_W        = 2,
    parameter int LEAK_LAT     = 1,
    parameter int DECAY_SHIFT  = 4,
    parameter int V_REST       = -70,
    parameter int V_TH         = -50,
    parameter int V_RESET      = -75,
    parameter int REFRAC_TICKS = 2
) (
    input logic                    clk,
    input logic                    rst,
    leak_update_sequencer_if.slave bus
);

    localparam int WAIT_W = (LEAK_LAT > 1) ? $clog2(LEAK_LAT) : 1;

    localparam logic signed [15:0] V_REST_16  = 16'(V_REST);
    localparam logic signed [15:0] V_TH_16    = 16'(V_TH);
    localparam logic signed [15:0] V_RESET_16 = 16'(V_RESET);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_NEURONS - 1);

    // Reject parameter sets the index/counter widths cannot represent.
    if (NUM_NEURONS < 2 || LEAK_LAT < 1 || REFRAC_TICKS < 0 ||
        (1 << IDX_W) < NUM_NEURONS) begin : g_bad_cfg
        $error("leak_update_sequencer: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [15:0]      v_mem [NUM_NEURONS];
    logic signed [15:0]      i_mem [NUM_NEURONS];
    logic        [IDX_W-1:0] idx_q;
    logic        [WAIT_W-1:0] wait_q;
    logic signed [15:0]      leak_v_q;
    logic                    spike_q;
    logic        [IDX_W-1:0] spike_idx_q;
    logic                    tick_drop_q;

    // Datapath for the neuron currently in UPDATE.
    logic signed [15:0] leak_shift;
    logic signed [17:0] sum;
    logic signed [15:0] v_new;
    logic               hold;     // neuron is refractory this sweep
    logic               fire;
    logic signed [15:0] v_wr;

`ifdef LEAK_SEQ_REFRAC_EN
    localparam int RC_W = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
    logic [RC_W-1:0] refrac_q [NUM_NEURONS];
    assign hold = (refrac_q[idx_q] != '0);
`else
    assign hold = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and Moore outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.tick) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                bus.busy = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                bus.busy = 1'b1;
                if (wait_q == '0) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                bus.busy = 1'b1;
                state_d  = (idx_q == LAST_IDX) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Integrate-and-fire arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        leak_shift = bus.leak_i >>> DECAY_SHIFT;
        // 18 bits hold any V + I_in - shifted leak without overflow.
        sum = 18'(v_mem[idx_q]) + 18'(i_mem[idx_q]) - 18'(leak_shift);
        if (sum > 18'sd32767) begin
            v_new = 16'sh7fff;
        end else if (sum < -18'sd32768) begin
            v_new = 16'sh8000;
        end else begin
            v_new = sum[15:0];
        end
        fire = !hold && (v_new >= V_TH_16);
        v_wr = (hold || fire) ? V_RESET_16 : v_new;
    end

    // ------------------------------------------------------------------
    // Register files, sweep index, leak handshake and output pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register files are reset explicitly because every
            // neuron must start from V_REST with zero injected current; they
            // are flops, not a RAM macro.
            for (int n = 0; n < NUM_NEURONS; n++) begin
                v_mem[n] <= V_REST_16;
                i_mem[n] <= '0;
`ifdef LEAK_SEQ_REFRAC_EN
                refrac_q[n] <= '0;
`endif
            end
            idx_q       <= '0;
            wait_q      <= '0;
            leak_v_q    <= '0;
            spike_q     <= 1'b0;
            spike_idx_q <= '0;
            tick_drop_q <= 1'b0;
        end else begin
            spike_q     <= 1'b0;
            tick_drop_q <= bus.tick && (state_q != S_IDLE);

            // A write landing in the same cycle as that neuron's UPDATE is
            // stored, but the update already read the old value.
            if (bus.iw_en) i_mem[bus.iw_idx] <= bus.iw_val;

            unique case (state_q)
                S_IDLE: begin
                    if (bus.tick) idx_q <= '0;
                end
                S_ISSUE: begin
                    leak_v_q <= v_mem[idx_q];
                    wait_q   <= WAIT_W'(LEAK_LAT - 1);
                end
                S_WAIT: begin
                    if (wait_q != '0) wait_q <= wait_q - 1'b1;
                end
                S_UPDATE: begin
                    v_mem[idx_q] <= v_wr;
                    if (fire) begin
                        spike_q     <= 1'b1;
                        spike_idx_q <= idx_q;
                    end
`ifdef LEAK_SEQ_REFRAC_EN
                    if (hold) begin
                        refrac_q[idx_q] <= refrac_q[idx_q] - 1'b1;
                    end else if (fire) begin
                        refrac_q[idx_q] <= RC_W'(REFRAC_TICKS);
                    end
`endif
                    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.leak_v    = leak_v_q;
    assign bus.spike     = spike_q;
    assign bus.spike_idx = spike_idx_q;
    assign bus.tick_drop = tick_drop_q;
    assign bus.rd_v      = v_mem[bus.rd_idx];

endmodule

// File: tb/tb_leak_update_sequencer.sv
// ----------------------------------------------------------------------------
// tb_leak_update_sequencer
//
// Drives sweeps, injected-current writes and stray ticks into
// leak_update_sequencer, with a behavioural leak unit (I_L = 3V + 210, one
// cycle latency). A reference model computes each sweep from the neuron
// equations; expected spike/done/tick_drop events go into queues that an
// independent monitor drains as the DUT emits them. V is read back through
// rd_v after every sweep.
// ----------------------------------------------------------------------------
module tb_leak_update_sequencer;

    localparam int N         = 4;
    localparam int IDX_W     = 2;
    localparam int LAT       = 1;
    localparam int SHIFT     = 4;
    localparam int V_REST    = -70;
    localparam int V_TH      = -50;
    localparam int V_RESET   = -75;
    localparam int REFRAC    = 2;
    localparam int SWEEP_CYC = N * (LAT + 2);

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    leak_update_sequencer_if #(.IDX_W(IDX_W)) bus ();

    leak_update_sequencer #(
        .NUM_NEURONS (N),
        .IDX_W       (IDX_W),
        .LEAK_LAT    (LAT),
        .DECAY_SHIFT (SHIFT),
        .V_REST      (V_REST),
        .V_TH        (V_TH),
        .V_RESET     (V_RESET),
        .REFRAC_TICKS(REFRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural leak unit, 16-bit result wraps like the real one.
    always @(posedge clk) bus.leak_i <= 16'(3 * int'(bus.leak_v) + 210);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int spikes_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int at;
        int idx;
    } ev_t;

    ev_t spike_q[$];
    int  done_q[$];
    int  drop_q[$];

    int mv[N];
    int mi[N];
    int mr[N];

    function automatic int leak_of(input int v);
        logic signed [15:0] l;
        l = 16'(3 * v + 210);
        return int'(l) >>> SHIFT;
    endfunction

    function automatic int sat16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = V_REST;
            mi[n] = 0;
            mr[n] = 0;
        end
        spike_q.delete();
        done_q.delete();
        drop_q.delete();
    endfunction

    // One sweep starting with tick in cycle 'base'. Neuron n is updated in
    // cycle base + n*(LAT+2) + LAT + 2; a current write in cycle wr_at only
    // reaches updates that happen strictly later.
    function automatic void plan_sweep(input int base, input int drop_at,
                                       input int wr_at, input int wr_idx,
                                       input int wr_val);
        for (int n = 0; n < N; n++) begin
            int upd;
            int i_use;
            int s;
            upd   = n * (LAT + 2) + LAT + 2;
            i_use = (wr_at >= 0 && wr_idx == n && wr_at < upd) ? wr_val : mi[n];
`ifdef LEAK_SEQ_REFRAC_EN
            if (mr[n] != 0) begin
                mv[n] = V_RESET;
                mr[n]--;
                continue;
            end
`endif
            s = sat16(mv[n] + i_use - leak_of(mv[n]));
            if (s >= V_TH) begin
                mv[n] = V_RESET;
                spike_q.push_back('{base + upd + 1, n});
`ifdef LEAK_SEQ_REFRAC_EN
                mr[n] = REFRAC;
`endif
            end else begin
                mv[n] = s;
            end
        end
        done_q.push_back(base + SWEEP_CYC + 1);
        if (drop_at >= 0) drop_q.push_back(base + drop_at + 1);
        if (wr_at >= 0) mi[wr_idx] = wr_val;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.spike) begin
                spikes_seen++;
                if (spike_q.size() == 0) begin
                    check("spike_unexpected", 1, 0);
                end else begin
                    ev_t e;
                    e = spike_q.pop_front();
                    check("spike_cycle", cyc, e.at);
                    check("spike_idx", int'(bus.spike_idx), e.idx);
                end
            end else if (spike_q.size() != 0 && spike_q[0].at <= cyc) begin
                void'(spike_q.pop_front());
                check("spike_missing", 0, 1);
            end

            if (bus.done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else check("done_cycle", cyc, done_q.pop_front());
            end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
                void'(done_q.pop_front());
                check("done_missing", 0, 1);
            end

            if (bus.tick_drop) begin
                if (drop_q.size() == 0) check("tick_drop_unexpected", 1, 0);
                else check("tick_drop_cycle", cyc, drop_q.pop_front());
            end else if (drop_q.size() != 0 && drop_q[0] <= cyc) begin
                void'(drop_q.pop_front());
                check("tick_drop_missing", 0, 1);
            end
        end
    end

    // ---------------- stimulus helpers (entered #1 after a posedge) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rd_is(input string name, input int n, input int exp);
        bus.rd_idx = IDX_W'(n);
        #1;
        check(name, int'(bus.rd_v), exp);
    endtask

    task automatic check_all_v(input string tag);
        for (int n = 0; n < N; n++) rd_is($sformatf("%s_v%0d", tag, n), n, mv[n]);
    endtask

    task automatic write_i(input int n, input int val);
        bus.iw_en  = 1'b1;
        bus.iw_idx = IDX_W'(n);
        bus.iw_val = 16'(val);
        step();
        bus.iw_en  = 1'b0;
        mi[n] = val;
    endtask

    task automatic sweep(input int drop_at, input int wr_at, input int wr_idx, input int wr_val);
        int base;
        int busy_cnt;
        int guard;
        base     = cyc;
        busy_cnt = 0;
        plan_sweep(base, drop_at, wr_at, wr_idx, wr_val);
        for (int k = 0; k < 20; k++) begin
            bus.tick   = (k == 0) || (k == drop_at);
            bus.iw_en  = (k == wr_at);
            bus.iw_idx = IDX_W'(wr_idx);
            bus.iw_val = 16'(wr_val);
            step();
            if (bus.busy) busy_cnt++;
        end
        bus.tick  = 1'b0;
        bus.iw_en = 1'b0;
        check("busy_cycles", busy_cnt, SWEEP_CYC);
        guard = 0;
        while ((spike_q.size() + done_q.size() + drop_q.size()) != 0 && guard < 10) begin
            step();
            guard++;
        end
        check("events_drained", spike_q.size() + done_q.size() + drop_q.size(), 0);
        check_all_v("sweep");
    endtask

    function automatic int rand_val();
        case ($urandom_range(0, 9))
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom_range(0, 60)) - 30;
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int s0;
        rst        = 1'b1;
        bus.tick   = 1'b0;
        bus.iw_en  = 1'b0;
        bus.iw_idx = '0;
        bus.iw_val = '0;
        bus.rd_idx = '0;
        step();
        do_reset();

        // Reset state
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_tick_drop", int'(bus.tick_drop), 0);
        check("rst_spike", int'(bus.spike), 0);
        check("rst_spike_idx", int'(bus.spike_idx), 0);
        check("rst_leak_v", int'(bus.leak_v), 0);
        for (int n = 0; n < N; n++) rd_is($sformatf("rst_v%0d", n), n, V_REST);

        // 1: quiet sweep, all V stay at rest
        sweep(-1, -1, 0, 0);

        // 2: I_in[2]=10 -> -60, -51, then spike back to V_RESET
        write_i(2, 10);
        s0 = spikes_seen;
        sweep(-1, -1, 0, 0);
        rd_is("t2_sweep1_v2", 2, -60);
        sweep(-1, -1, 0, 0);
        rd_is("t2_sweep2_v2", 2, -51);
        sweep(-1, -1, 0, 0);
        rd_is("t2_sweep3_v2", 2, V_RESET);
        rd_is("t2_sweep3_v0", 0, V_REST);
        check("t2_spike_count", spikes_seen - s0, 1);

`ifdef LEAK_SEQ_REFRAC_EN
        // 6: refractory hold for REFRAC sweeps, then integration resumes
        sweep(-1, -1, 0, 0);
        rd_is("t6_hold1_v2", 2, V_RESET);
        sweep(-1, -1, 0, 0);
        rd_is("t6_hold2_v2", 2, V_RESET);
        sweep(-1, -1, 0, 0);
`endif

        // 3: most negative current saturates instead of wrapping
        write_i(1, -32768);
        sweep(-1, -1, 0, 0);
        rd_is("t3_v1_sat", 1, -32768);
        write_i(1, 0);

        // 4: stray tick 5 cycles into a sweep
        sweep(5, -1, 0, 0);

        // 5: reset in cycle 6 of a sweep
        do_reset();
        for (int n = 0; n < N; n++) write_i(n, 5);
        for (int k = 0; k <= 6; k++) begin
            bus.tick = (k == 0);
            rst      = (k == 6);
            step();
        end
        bus.tick = 1'b0;
        rst      = 1'b0;
        check("t5_busy_after_rst", int'(bus.busy), 0);
        model_reset();
        repeat (16) step();
        check_all_v("t5_after_rst");
        sweep(-1, -1, 0, 0);

        // Randomised sweeps: currents, stray ticks (incl. during DONE) and
        // writes that may coincide with the target neuron's UPDATE.
        for (int r = 0; r < 14; r++) begin
            int drop_at;
            int wr_at;
            int wr_idx;
            if ($urandom_range(0, 1) == 1) write_i(int'($urandom_range(0, N - 1)), rand_val());
            drop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, SWEEP_CYC + 1)) : -1;
            wr_idx  = int'($urandom_range(0, N - 1));
            case ($urandom_range(0, 2))
                0:       wr_at = -1;
                1:       wr_at = wr_idx * (LAT + 2) + LAT + 2;
                default: wr_at = int'($urandom_range(0, 14));
            endcase
            sweep(drop_at, wr_at, wr_idx, rand_val());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
